// File: rtl/reg_file_64_pkg.sv
// Package: reg_file_64_pkg
// Shared widths, the zero-register index and the clear-sequencer state
// encoding for the 32 x 64-bit register file.
//   DATA_W   : register / data bus width
//   ADDR_W   : register index width
//   ZERO_REG : hard-wired zero register (XZR)
//   ZERO_IDX : ZERO_REG at index width, for compares against RA/RB/RW
//   CLR_LAST : last index touched by the post-reset clear (ZERO_REG-1)
//   DEPTH    : number of addressable entries (2**ADDR_W)
//   rf_state_t : CLEAR = 1'b0 (sequencer zeroing storage), RUN = 1'b1
package reg_file_64_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;
   localparam int DEPTH    = 1 << ADDR_W;

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(ZERO_REG - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Module: regfile_init_ctrl
// Post-reset clear sequencer. After Reset it walks ClrAddr from 0 up to
// ZERO_REG-1, asserting ClrWe for one entry per clock, then parks in RUN.
// Ports:
//   Clk       in  : clock, all updates on posedge
//   Reset     in  : asynchronous active-high reset, restarts the clear
//   ClrWe     out : 1 while the clear is in progress (write zero this cycle)
//   ClrAddr   out : entry being cleared this cycle
//   Ready     out : 1 once the clear has completed (state == RUN)
//   CtrlState out : current sequencer state, for observation
module regfile_init_ctrl
   import reg_file_64_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   output logic              ClrWe,
   output logic [ADDR_W-1:0] ClrAddr,
   output logic              Ready,
   output rf_state_t         CtrlState
);

   rf_state_t         state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] clr_cnt_nxt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         CtrlState <= CLEAR;
         clr_cnt   <= '0;
      end else begin
         CtrlState <= state_nxt;
         clr_cnt   <= clr_cnt_nxt;
      end
   end

   // The counter holds at CLR_LAST on the final clear edge instead of
   // incrementing, so it never reaches ZERO_REG and never wraps.
   always_comb begin
      state_nxt   = CtrlState;
      clr_cnt_nxt = clr_cnt;
      ClrWe       = 1'b0;
      case (CtrlState)
         CLEAR: begin
            ClrWe = 1'b1;
            if (clr_cnt == CLR_LAST) begin
               state_nxt = RUN;
            end else begin
               clr_cnt_nxt = clr_cnt + 1'b1;
            end
         end
         RUN: begin
            state_nxt = RUN;
         end
      endcase
   end

   assign ClrAddr = clr_cnt;

   // Ready is a level, not a handshake: the file may be read and written
   // on any cycle where Ready=1; while Ready=0 writes are ignored and all
   // read ports return zero. No back-pressure exists in either direction.
   assign Ready = (CtrlState == RUN);

endmodule

// File: rtl/reg_file_64.sv
// Module: reg_file_64
// 32-entry x 64-bit register file with two combinational read ports
// (BusA, BusB), one synchronous write port (BusW) and a debug read port.
// X31 reads zero and ignores writes. Storage is not reset; instead the
// regfile_init_ctrl sequencer zeroes X0..X30 after every Reset.
// Ports:
//   Clk, Reset     : clock, asynchronous active-high reset
//   RA, RB         : read indices for BusA / BusB
//   RW, BusW, RegWr: write index, write data, write enable
//   BusA, BusB     : read data (write-first bypass from BusW)
//   Ready          : 1 once the post-reset clear has finished
//   DbgAddr        : debug read index
//   DbgData        : debug read data (storage only, no bypass)
module reg_file_64
   import reg_file_64_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   input  logic [ADDR_W-1:0] RW,
   input  logic [DATA_W-1:0] BusW,
   input  logic              RegWr,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   output logic              Ready,
   input  logic [ADDR_W-1:0] DbgAddr,
   output logic [DATA_W-1:0] DbgData
);

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   rf_state_t         ctrl_state;
   logic              run;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              user_wr;

   logic [DATA_W-1:0] mem [DEPTH];

   regfile_init_ctrl u_init_ctrl (
      .Clk       (Clk),
      .Reset     (Reset),
      .ClrWe     (clr_we),
      .ClrAddr   (clr_addr),
      .Ready     (Ready),
      .CtrlState (ctrl_state)
   );

   assign run     = (ctrl_state == RUN);
   assign user_wr = run && RegWr && (RW != ZERO_IDX);

   // The clear path owns the write port until the sequencer reaches RUN.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = RW;
      wr_data = BusW;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
      end else if (user_wr) begin
         wr_en = 1'b1;
      end
   end

   // Storage has no reset; gating on Reset keeps clock edges inert while
   // Reset is held.
   always_ff @(posedge Clk) begin
      if (!Reset && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Entry ZERO_REG is never written; it is masked on every read path.
   // The bypass compare needs no RW!=ZERO_IDX term because the read index
   // has already been checked against ZERO_IDX.
   always_comb begin
      BusA    = '0;
      BusB    = '0;
      DbgData = '0;
      if (run) begin
         if (RA != ZERO_IDX) begin
            BusA = (RegWr && (RW == RA)) ? BusW : mem[RA];
         end
         if (RB != ZERO_IDX) begin
            BusB = (RegWr && (RW == RB)) ? BusW : mem[RB];
         end
         if (DbgAddr != ZERO_IDX) begin
            DbgData = mem[DbgAddr];
         end
      end
   end

endmodule

// File: tb/tb_reg_file_64.sv
module tb_reg_file_64;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  RA = '0;
  logic [4:0]  RB = '0;
  logic [4:0]  RW = '0;
  logic [4:0]  DbgAddr = '0;
  logic [63:0] BusW = '0;
  logic        RegWr = 1'b0;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [63:0] DbgData;
  logic        Ready;

  logic [63:0] exp_q[$];
  logic [63:0] model [32];
  int          total = 0;
  int          bad = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  reg_file_64 dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .RA      (RA),
    .RB      (RB),
    .RW      (RW),
    .BusW    (BusW),
    .RegWr   (RegWr),
    .BusA    (BusA),
    .BusB    (BusB),
    .Ready   (Ready),
    .DbgAddr (DbgAddr),
    .DbgData (DbgData)
  );

  // ---------------- scoreboard ----------------
  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] idx);
    return (idx == 5'd31) ? 64'h0 : model[idx];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] v);
    RegWr = 1'b1;
    RW    = idx;
    BusW  = v;
    tick();
    RegWr = 1'b0;
    if (idx != 5'd31) model[idx] = v;
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [4:0] b, input string tag);
    RA      = a;
    RB      = b;
    DbgAddr = a;
    #1;
    expect_v(exp_rd(a)); check({tag, "_busa"}, BusA);
    expect_v(exp_rd(b)); check({tag, "_busb"}, BusB);
    expect_v(exp_rd(a)); check({tag, "_dbg"}, DbgData);
  endtask

  // Counts n edges after Reset deasserts; Ready must rise exactly on edge 31.
  task automatic clear_edges(input int n, input string tag);
    for (int e = 1; e <= n; e++) begin
      RA = 5'($urandom_range(0, 31));
      RB = 5'($urandom_range(0, 31));
      tick();
      expect_v({63'h0, (e == 31)}); check({tag, "_ready"}, {63'h0, Ready});
      if (e < 31) begin
        expect_v(64'h0); check({tag, "_busa_clr"}, BusA);
        expect_v(64'h0); check({tag, "_busb_clr"}, BusB);
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    Reset = 1'b1;
    #1;
    expect_v(64'h0); check({tag, "_ready_async"}, {63'h0, Ready});
    expect_v(64'h0); check({tag, "_busa_async"}, BusA);
    tick();
    Reset = 1'b0;
    clear_model();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0]  idx;
    logic [63:0] v;
    logic [63:0] sum;

    clear_model();

    // 1. reset and clear timing
    #2;
    expect_v(64'h0); check("rst_ready", {63'h0, Ready});
    expect_v(64'h0); check("rst_busa", BusA);
    expect_v(64'h0); check("rst_busb", BusB);
    expect_v(64'h0); check("rst_dbg", DbgData);
    tick();
    Reset = 1'b0;
    clear_edges(31, "clr1");
    for (int i = 0; i < 32; i++) read_chk(5'(i), 5'(31 - i), "post_clr");

    // 2. write then read on both ports
    write_reg(5'd5, 64'hDEAD_BEEF_0123_4567);
    read_chk(5'd5, 5'd5, "x5");

    // 3. same-cycle RAW bypass; debug port sees storage only
    RegWr = 1'b1; RW = 5'd7; BusW = 64'h55; RA = 5'd7; RB = 5'd8; DbgAddr = 5'd7;
    #1;
    expect_v(64'h55); check("raw_bypass_a", BusA);
    expect_v(exp_rd(5'd8)); check("raw_other_b", BusB);
    expect_v(64'h0); check("raw_dbg_nobypass", DbgData);
    tick();
    RegWr = 1'b0; BusW = 64'h0; model[7] = 64'h55;
    #1;
    expect_v(64'h55); check("raw_stored_a", BusA);
    expect_v(64'h55); check("raw_stored_dbg", DbgData);

    // RA==RB==RW with write enabled
    RegWr = 1'b1; RW = 5'd12; BusW = 64'h0ABC_0000_1234; RA = 5'd12; RB = 5'd12;
    #1;
    expect_v(64'h0ABC_0000_1234); check("triple_a", BusA);
    expect_v(64'h0ABC_0000_1234); check("triple_b", BusB);
    tick();
    RegWr = 1'b0; model[12] = 64'h0ABC_0000_1234;
    read_chk(5'd12, 5'd7, "triple_stored");

    // 4. writes to X31 are dropped and never bypassed
    RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF_FFFF_FFFF_FFFF;
    RA = 5'd31; RB = 5'd31; DbgAddr = 5'd31;
    #1;
    expect_v(64'h0); check("xzr_a_wr", BusA);
    expect_v(64'h0); check("xzr_b_wr", BusB);
    expect_v(64'h0); check("xzr_dbg_wr", DbgData);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_v(64'h0); check("xzr_a_after", BusA);
      expect_v(64'h0); check("xzr_dbg_after", DbgData);
    end
    RegWr = 1'b0;
    read_chk(5'd5, 5'd12, "xzr_others");

    // random writes/reads against the model
    for (int k = 0; k < 40; k++) begin
      idx = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        v = {$urandom, $urandom};
        write_reg(idx, v);
      end else begin
        read_chk(idx, 5'($urandom_range(0, 31)), "rand");
      end
    end

    // 5. fill, then reset mid-operation and mid-clear
    for (int i = 0; i < 31; i++) write_reg(5'(i), 64'(i + 1));
    for (int k = 0; k < 5; k++) begin
      idx = 5'($urandom_range(0, 30));
      read_chk(idx, 5'($urandom_range(0, 31)), "fill");
    end
    RA = 5'd10;
    pulse_reset("rst_mid_run");
    RegWr = 1'b1; RW = 5'd3; BusW = 64'h9;
    clear_edges(10, "clr_part");
    pulse_reset("rst_mid_clr");
    RegWr = 1'b1; RW = 5'd3; BusW = 64'h9;
    clear_edges(31, "clr2");
    RegWr = 1'b0;
    for (int i = 0; i < 32; i++) read_chk(5'(i), 5'(i), "post_clr2");

    // 6. operands for an attached ALU ADD
    write_reg(5'd10, 64'h1);
    write_reg(5'd11, 64'h2);
    read_chk(5'd10, 5'd11, "alu_ops");
    sum = BusA + BusB;
    expect_v(64'h3); check("alu_add", sum);
    expect_v(64'h0); check("alu_zero", {63'h0, (sum == 64'h0)});

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
